serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Parametrised serial frame receiver for the DUT's argument/command link. It deserialises `WORD_W = DATA_W+2`-bit words (type bit, data MSB first, parity bit) from `din`, gated by active-low `enable_n`. It collects data words into an argument array until a command word closes the frame, then presents the whole frame with a status vector on a valid/ready interface. It is the generalised successor of the fixed 8-bit, 2–9-argument input stage: data width, argument depth and parity sense are configurable, and it adds overrun/framing detection and output backpressure.

## Interface
- `DATA_W`, 8, payload bits per word.
- `MAX_ARGS`, 9, argument slots stored per frame.
- `MIN_ARGS`, 2, fewest data words in a legal frame.
- `ODD_PARITY`, 0, 0: XOR over all `WORD_W` bits must be 0; 1: XOR must be 1.

Ports:
- `clk`  in  1  clock; all sampling on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  1  serial data, valid while `enable_n`=0.
- `enable_n`  in  1  frame gate, active low.
- `frame_valid`  out  1  frame available.
- `frame_ready`  in  1  consumer accepts frame.
- `frame_cmd`  out  `DATA_W`  command payload.
- `frame_args`  out  `MAX_ARGS*DATA_W`  argument i at `[i*DATA_W +: DATA_W]`; unused slots 0.
- `frame_nargs`  out  `$clog2(MAX_ARGS+1)`  data words stored.
- `frame_status`  out  4  bit0 parity error, bit1 argument-count error, bit2 framing error, bit3 overrun.

## Operation
- States: IDLE, SHIFT, HOLD, DRAIN.
- IDLE: on the first edge with `enable_n`=0, sample `din` as bit 0, clear args/nargs/status, go to SHIFT.
- SHIFT: sample one bit per edge while `enable_n`=0.
  - Bit 0 is the type: 1 = command, 0 = data. Then `DATA_W` data bits, MSB first. The last bit is parity.
  - Bit counter runs 0..`WORD_W`-1 and wraps to 0 at word end.
- Word complete:
  - Parity mismatch sets sticky bit0. The word is still used.
  - Data word with nargs < `MAX_ARGS`: store at slot nargs, nargs++.
  - Data word with nargs = `MAX_ARGS`: discard it and set bit1.
  - Command word: latch `frame_cmd`. If nargs < `MIN_ARGS`, set bit1. Go to HOLD.
- `enable_n` rises in SHIFT (any point after the first bit, before the command word completes):
  - set bit2 and `frame_cmd`=0, go to HOLD;
  - the partial word is dropped and stored args are kept.
- HOLD: `frame_valid`=1, and all frame outputs stay stable until the `frame_valid`&&`frame_ready` edge.
  - `din` is ignored in HOLD.
  - If `enable_n`=0 on any edge in HOLD, set a pending-overrun flag. It is copied into bit3 of the next frame.
  - After the handshake edge: if `enable_n`=0, go to DRAIN, else go to IDLE.
- DRAIN: wait for `enable_n`=1, then go to IDLE. Bits arriving in DRAIN are lost.
- Command word with `enable_n` still low afterwards: extra bits are ignored via HOLD/DRAIN and overrun is set.

## Timing
- Reset (asynchronous, any state): state IDLE, `frame_valid`=0, `frame_cmd`=0, `frame_args`=0, `frame_nargs`=0, `frame_status`=0, pending overrun 0. A partial frame is lost.
- Latency: `frame_valid` rises one clock after the edge that samples the command word's parity bit. For a framing error, it rises one clock after the edge where `enable_n`=1 is first seen.
- `frame_ready` may be high before `frame_valid`. The handshake then completes on the first HOLD edge, and `frame_valid` is high for exactly one cycle.
- Earliest next frame: the first bit is accepted on the edge after the handshake edge, provided `enable_n` was high at the handshake edge.
- Reset beats every other event in the same cycle.
- Data and command in the same frame never collide: one word completes per `WORD_W` edges.

## Structure
- Package `serial_frame_pkg`:
  - state enum `rx_state_t`;
  - status bit index localparams `ST_PERR`, `ST_CNT`, `ST_FRM`, `ST_OVR`;
  - word-type constants `WT_DATA`=0, `WT_CMD`=1.
- Sub-module `serial_word_shifter`:
  - contains the shift register, bit counter and parity check;
  - outputs `word_done`, `word_type`, `word_data[DATA_W-1:0]`, `word_perr`, `mid_word`;
  - clears on `rst` or on `enable_n`=1.
- Top level holds the FSM, argument array, nargs counter and status flags.

## Test plan
Defaults (`DATA_W`=8, `MAX_ARGS`=9, `MIN_ARGS`=2, even parity):
- Data 0x12, 0x34, command 0x01, correct parity -> `frame_valid` one clock after the 30th sampled bit; nargs=2, args[7:0]=0x12, args[15:8]=0x34, cmd=0x01, status=4'b0000.
- Nine data words 0xFF + command 0x00 -> nargs=9, status=0. Ten data words 0xFF -> nargs=9, status=4'b0010.
- One data word 0x00 + command 0x03 -> nargs=1, status=4'b0010.
- Data 0xA5, 0x5A with the second word's parity inverted, command 0x04 -> args stored, status=4'b0001.
- `enable_n` rises after 5 bits of the second data word -> cmd=0, nargs=1, status=4'b0100.
- `frame_ready` held low 20 cycles while `enable_n` drops -> next clean frame reports status=4'b1000. Then `rst` pulsed mid-frame -> all outputs 0, and a following clean frame decodes correctly.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DRAIN
  } rx_state_t;

  // Bit positions within frame_status
  localparam int ST_PERR = 0;
  localparam int ST_CNT  = 1;
  localparam int ST_FRM  = 2;
  localparam int ST_OVR  = 3;

  // Value of the leading type bit of each word
  localparam logic WT_DATA = 1'b0;
  localparam logic WT_CMD  = 1'b1;

endpackage

// File: rtl/serial_word_shifter.sv
// Deserialises one word (type, data MSB first, parity) per WORD_W sampled bits.
// word_* outputs are combinational and valid on the edge that samples the parity bit.
module serial_word_shifter #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_n,
  input  logic              shift_en,
  input  logic              din,
  output logic              word_done,
  output logic              word_type,
  output logic [DATA_W-1:0] word_data,
  output logic              word_perr,
  output logic              mid_word
);

  localparam int WORD_W = DATA_W + 2;
  localparam int CW     = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

  logic [DATA_W:0] sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            par_q, par_d;
  logic            take;
  logic            odd_sense;

  // Next-state for shift register, bit counter and running parity; word decode
  always_comb begin
    take      = shift_en && !enable_n;
    odd_sense = (ODD_PARITY != 0);
    word_done = take && (cnt_q == LAST_BIT);
    // After WORD_W-1 shifts the register holds {type, data}; din is the parity bit
    word_type = sreg_q[DATA_W];
    word_data = sreg_q[DATA_W-1:0];
    word_perr = ((par_q ^ din) != odd_sense);
    mid_word  = (cnt_q != '0);

    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    par_d  = par_q;
    if (enable_n) begin
      sreg_d = '0;
      cnt_d  = '0;
      par_d  = 1'b0;
    end else if (take) begin
      sreg_d = {sreg_q[DATA_W-1:0], din};
      if (word_done) begin
        cnt_d = '0;
        par_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        par_d = par_q ^ din;
      end
    end
  end

  // Shifter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      par_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      par_q  <= par_d;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: collects data words into an argument array until a
// command word closes the frame, then offers it on a valid/ready interface.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_ARGS   = 9,
  parameter int MIN_ARGS   = 2,
  parameter int ODD_PARITY = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din,
  input  logic                           enable_n,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic [DATA_W-1:0]              frame_cmd,
  output logic [MAX_ARGS*DATA_W-1:0]     frame_args,
  output logic [$clog2(MAX_ARGS+1)-1:0]  frame_nargs,
  output logic [3:0]                     frame_status
);

  localparam int NW = $clog2(MAX_ARGS + 1);
  localparam logic [NW-1:0] MIN_N = NW'(MIN_ARGS);
  localparam logic [NW-1:0] MAX_N = NW'(MAX_ARGS);

  rx_state_t                    state_q, state_d;
  logic [DATA_W-1:0]            cmd_q, cmd_d;
  logic [MAX_ARGS*DATA_W-1:0]   args_q, args_d;
  logic [NW-1:0]                nargs_q, nargs_d;
  logic [3:0]                   status_q, status_d;
  logic                         ovr_pend_q, ovr_pend_d;

  logic                         shift_en;
  logic                         word_done;
  logic                         word_type;
  logic [DATA_W-1:0]            word_data;
  logic                         word_perr;
  // Framing errors are decided from enable_n alone, so the partial-word flag is not consumed
  logic                         unused_mid_word;

  assign shift_en = (state_q == IDLE) || (state_q == SHIFT);

  serial_word_shifter #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .enable_n  (enable_n),
    .shift_en  (shift_en),
    .din       (din),
    .word_done (word_done),
    .word_type (word_type),
    .word_data (word_data),
    .word_perr (word_perr),
    .mid_word  (unused_mid_word)
  );

  // Frame FSM next-state, argument storage and status accumulation
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    args_d      = args_q;
    nargs_d     = nargs_q;
    status_d    = status_q;
    ovr_pend_d  = ovr_pend_q;
    frame_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!enable_n) begin
          // Overrun seen while the previous frame was held belongs to this frame
          args_d            = '0;
          nargs_d           = '0;
          cmd_d             = '0;
          status_d          = '0;
          status_d[ST_OVR]  = ovr_pend_q;
          ovr_pend_d        = 1'b0;
          state_d           = SHIFT;
        end
      end
      SHIFT: begin
        if (enable_n) begin
          status_d[ST_FRM] = 1'b1;
          cmd_d            = '0;
          state_d          = HOLD;
        end else if (word_done) begin
          if (word_perr) status_d[ST_PERR] = 1'b1;
          if (word_type == WT_CMD) begin
            cmd_d = word_data;
            if (nargs_q < MIN_N) status_d[ST_CNT] = 1'b1;
            state_d = HOLD;
          end else if (nargs_q < MAX_N) begin
            for (int unsigned i = 0; i < MAX_ARGS; i++) begin
              if (nargs_q == NW'(i)) args_d[i*DATA_W +: DATA_W] = word_data;
            end
            nargs_d = nargs_q + 1'b1;
          end else begin
            status_d[ST_CNT] = 1'b1;
          end
        end
      end
      HOLD: begin
        frame_valid = 1'b1;
        if (!enable_n) ovr_pend_d = 1'b1;
        if (frame_ready) state_d = enable_n ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enable_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      args_q     <= '0;
      nargs_q    <= '0;
      status_q   <= '0;
      ovr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      args_q     <= args_d;
      nargs_q    <= nargs_d;
      status_q   <= status_d;
      ovr_pend_q <= ovr_pend_d;
    end
  end

  assign frame_cmd    = cmd_q;
  assign frame_args   = args_q;
  assign frame_nargs  = nargs_q;
  assign frame_status = status_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed and randomized frames checked against a word-list reference model.
module tb_serial_frame_rx;

  localparam int DATA_W     = 8;
  localparam int MAX_ARGS   = 9;
  localparam int MIN_ARGS   = 2;
  localparam int ODD_PARITY = 0;
  localparam int WORD_W     = DATA_W + 2;
  localparam int NW         = $clog2(MAX_ARGS + 1);

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       din;
  logic                       enable_n;
  logic                       frame_ready;
  logic                       frame_valid;
  logic [DATA_W-1:0]          frame_cmd;
  logic [MAX_ARGS*DATA_W-1:0] frame_args;
  logic [NW-1:0]              frame_nargs;
  logic [3:0]                 frame_status;

  int checks = 0;
  int errors = 0;

  bit                w_cmd[$];
  logic [DATA_W-1:0] w_data[$];
  bit                w_bad[$];
  bit                bits_q[$];

  logic [DATA_W-1:0]          e_cmd;
  logic [MAX_ARGS*DATA_W-1:0] e_args;
  int                         e_nargs;
  logic [3:0]                 e_status;

  serial_frame_rx #(
    .DATA_W     (DATA_W),
    .MAX_ARGS   (MAX_ARGS),
    .MIN_ARGS   (MIN_ARGS),
    .ODD_PARITY (ODD_PARITY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .enable_n     (enable_n),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_cmd    (frame_cmd),
    .frame_args   (frame_args),
    .frame_nargs  (frame_nargs),
    .frame_status (frame_status)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_words();
    w_cmd.delete();
    w_data.delete();
    w_bad.delete();
  endtask

  task automatic add_word(input bit c, input logic [DATA_W-1:0] d, input bit bad);
    w_cmd.push_back(c);
    w_data.push_back(d);
    w_bad.push_back(bad);
  endtask

  // Serialise the word list; cut >= 0 keeps only the first cut bits
  task automatic build_bits(input int cut);
    bit p;
    bits_q.delete();
    foreach (w_cmd[i]) begin
      p = w_cmd[i] ^ (^w_data[i]) ^ (ODD_PARITY != 0) ^ w_bad[i];
      bits_q.push_back(w_cmd[i]);
      for (int b = DATA_W - 1; b >= 0; b--) bits_q.push_back(w_data[i][b]);
      bits_q.push_back(p);
    end
    if (cut >= 0) while (bits_q.size() > cut) void'(bits_q.pop_back());
  endtask

  // Expected frame from the words that were fully delivered before enable_n rose
  task automatic model(input int sent, input bit ovr);
    bit done = 1'b0;
    e_cmd = '0; e_args = '0; e_nargs = 0; e_status = '0;
    e_status[3] = ovr;
    foreach (w_cmd[i]) begin
      if (done || (i + 1) * WORD_W > sent) break;
      if (w_bad[i]) e_status[0] = 1'b1;
      if (w_cmd[i]) begin
        e_cmd = w_data[i];
        if (e_nargs < MIN_ARGS) e_status[1] = 1'b1;
        done = 1'b1;
      end else if (e_nargs < MAX_ARGS) begin
        e_args[e_nargs*DATA_W +: DATA_W] = w_data[i];
        e_nargs++;
      end else begin
        e_status[1] = 1'b1;
      end
    end
    if (!done) begin
      e_status[2] = 1'b1;
      e_cmd = '0;
    end
  endtask

  task automatic send_bits();
    foreach (bits_q[i]) begin
      @(negedge clk);
      enable_n = 1'b0;
      din      = bits_q[i];
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    enable_n = 1'b1;
    din      = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (frame_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 128'(frame_valid), 128'(1'b1));
    chk({tag, "_cmd"}, 128'(frame_cmd), 128'(e_cmd));
    chk({tag, "_args"}, 128'(frame_args), 128'(e_args));
    chk({tag, "_nargs"}, 128'(frame_nargs), 128'(e_nargs));
    chk({tag, "_status"}, 128'(frame_status), 128'(e_status));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk({tag, "_released"}, 128'(frame_valid), 128'(1'b0));
  endtask

  task automatic run_frame(input string tag, input int cut, input bit ovr);
    int lat;
    build_bits(cut);
    model(bits_q.size(), ovr);
    send_bits();
    chk({tag, "_pre_valid"}, 128'(frame_valid), 128'(1'b0));
    end_frame();
    wait_valid(lat);
    chk({tag, "_latency"}, 128'(lat), 128'(e_status[2] ? 1 : 0));
    check_outputs(tag);
    handshake(tag);
  endtask

  initial begin
    int lat;
    int n;
    int cut;
    rst = 1'b1; enable_n = 1'b1; din = 1'b0; frame_ready = 1'b0;
    #12;
    chk("rst_valid", 128'(frame_valid), 128'(1'b0));
    chk("rst_cmd", 128'(frame_cmd), 128'(0));
    chk("rst_args", 128'(frame_args), 128'(0));
    chk("rst_nargs", 128'(frame_nargs), 128'(0));
    chk("rst_status", 128'(frame_status), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Basic two-argument frame
    clear_words();
    add_word(1'b0, 8'h12, 1'b0); add_word(1'b0, 8'h34, 1'b0); add_word(1'b1, 8'h01, 1'b0);
    run_frame("basic", -1, 1'b0);

    // Nine arguments: full but legal
    clear_words();
    for (int i = 0; i < 9; i++) add_word(1'b0, 8'hFF, 1'b0);
    add_word(1'b1, 8'h00, 1'b0);
    run_frame("nine", -1, 1'b0);

    // Ten arguments: one discarded
    clear_words();
    for (int i = 0; i < 10; i++) add_word(1'b0, 8'hFF, 1'b0);
    add_word(1'b1, 8'h00, 1'b0);
    run_frame("ten", -1, 1'b0);

    // Too few arguments
    clear_words();
    add_word(1'b0, 8'h00, 1'b0); add_word(1'b1, 8'h03, 1'b0);
    run_frame("few", -1, 1'b0);

    // Parity error on second data word
    clear_words();
    add_word(1'b0, 8'hA5, 1'b0); add_word(1'b0, 8'h5A, 1'b1); add_word(1'b1, 8'h04, 1'b0);
    run_frame("parity", -1, 1'b0);

    // Framing error 5 bits into the second data word
    clear_words();
    add_word(1'b0, 8'h77, 1'b0); add_word(1'b0, 8'h88, 1'b0); add_word(1'b1, 8'h09, 1'b0);
    run_frame("framing", WORD_W + 5, 1'b0);

    // Overrun: enable_n drops while the frame is held
    clear_words();
    add_word(1'b0, 8'($urandom), 1'b0); add_word(1'b0, 8'($urandom), 1'b0);
    add_word(1'b1, 8'($urandom), 1'b0);
    build_bits(-1);
    model(bits_q.size(), 1'b0);
    send_bits();
    end_frame();
    wait_valid(lat);
    check_outputs("ovr_a");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enable_n = !(i >= 5 && i < 10);
      din      = 1'($urandom);
    end
    check_outputs("ovr_a_stable");
    handshake("ovr_a");
    clear_words();
    add_word(1'b0, 8'($urandom), 1'b0); add_word(1'b0, 8'($urandom), 1'b0);
    add_word(1'b1, 8'($urandom), 1'b0);
    run_frame("ovr_b", -1, 1'b1);

    // Ready high early, command followed by extra bits: one-cycle valid, drain, overrun
    clear_words();
    for (int i = 0; i < 3; i++) add_word(1'b0, 8'($urandom), 1'b0);
    add_word(1'b1, 8'($urandom), 1'b0);
    build_bits(-1);
    model(bits_q.size(), 1'b0);
    frame_ready = 1'b1;
    send_bits();
    chk("early_pre_valid", 128'(frame_valid), 128'(1'b0));
    @(negedge clk);
    din = 1'($urandom);
    check_outputs("early");
    @(negedge clk);
    din = 1'($urandom);
    chk("early_one_cycle", 128'(frame_valid), 128'(1'b0));
    @(negedge clk);
    enable_n = 1'b1; frame_ready = 1'b0;
    @(negedge clk);
    clear_words();
    add_word(1'b0, 8'($urandom), 1'b0); add_word(1'b0, 8'($urandom), 1'b0);
    add_word(1'b1, 8'($urandom), 1'b0);
    run_frame("after_drain", -1, 1'b1);

    // Randomized frames, some with parity errors or truncation
    for (int k = 0; k < 10; k++) begin
      clear_words();
      n = $urandom_range(0, 11);
      for (int i = 0; i < n; i++) add_word(1'b0, 8'($urandom), $urandom_range(0, 7) == 0);
      add_word(1'b1, 8'($urandom), $urandom_range(0, 7) == 0);
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (n + 1) * WORD_W - 1)) : -1;
      run_frame("rand", cut, 1'b0);
    end

    // Reset mid-frame, then a clean frame
    clear_words();
    add_word(1'b0, 8'hC3, 1'b0); add_word(1'b0, 8'h3C, 1'b0); add_word(1'b1, 8'h11, 1'b0);
    build_bits(15);
    send_bits();
    chk("mid_nargs", 128'(frame_nargs), 128'(1));
    @(posedge clk);
    #2;
    rst = 1'b1; enable_n = 1'b1;
    #1;
    chk("mrst_valid", 128'(frame_valid), 128'(1'b0));
    chk("mrst_cmd", 128'(frame_cmd), 128'(0));
    chk("mrst_args", 128'(frame_args), 128'(0));
    chk("mrst_nargs", 128'(frame_nargs), 128'(0));
    chk("mrst_status", 128'(frame_status), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    run_frame("post_rst", -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
